cordic_sched: RTL

- Shares one 16-stage `cordic` pipeline between NUM_REQ requesters.
- Arbitrates theta requests round-robin and issues at most one per cycle.
- Tracks each in-flight requester ID in a delay line matched to the pipeline latency.
- Buffers results in a response FIFO with a single valid/ready port tagged by requester ID.
- Credit-based issue guarantees the no-stall pipeline never overflows the FIFO.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_rr_arb.sv | 43 ++++
 rtl/cordic_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the cordic request scheduler.
package cordic_pkg;

    typedef logic [31:0] theta_t;
    typedef logic [15:0] short_t;

    // Latency of the shared cordic pipeline (valid_in to valid_out).
    localparam int CORDIC_PIPE_LATENCY = 16;

    // Widest requester ID the scheduler supports (NUM_REQ up to 8).
    localparam int ID_MAX_W = 3;

    // One buffered result, tagged with the requester that issued it.
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        short_t              cos;
        short_t              sin;
    } rsp_entry_t;

endpackage

// File: rtl/cordic_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searching from the
// entry after the last winner; the pointer moves only when told to.
module cordic_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    input  logic          i_adv,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] r_last;
    int            w_c;

    // Search req from r_last+1 upward, wrapping, and take the first hit.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_c   = 0;
        for (int off = 1; off <= N; off++) begin
            w_c = int'(r_last) + off;
            if (w_c >= N) w_c = w_c - N;
            if (i_en && !o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_idx      = IW'(w_c);
                o_gnt[w_c] = 1'b1;
            end
        end
    end

    // Remember the winner of an accepted grant; reset gives index 0 first turn.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_last <= IW'(N - 1);
        else if (i_adv) r_last <= o_idx;
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one cordic pipeline between NUM_REQ requesters. Requests are
// issued round-robin under a credit limit equal to the response FIFO depth,
// tagged through a delay line matched to the pipeline, and returned in issue
// order through a single valid/ready port.
// Optional: define CORDIC_SCHED_STATS_EN to add per-requester issue counters
// and a credit-stall counter.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int PIPE_LATENCY = CORDIC_PIPE_LATENCY,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ-1:0][31:0]   i_req_theta,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_cordic_valid_in,
    output logic [31:0]                o_cordic_theta_in,
    input  logic                       i_cordic_valid_out,
    input  logic [15:0]                i_cordic_cos,
    input  logic [15:0]                i_cordic_sin,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [ID_W-1:0]            o_rsp_id,
    output logic [15:0]                o_rsp_cos,
    output logic [15:0]                o_rsp_sin,
    output logic                       o_err
`ifdef CORDIC_SCHED_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]   o_issue_cnt,
    output logic [15:0]                o_stall_cnt
`endif
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);

    // Issue / credit
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_xfer;
    logic               w_can_issue;
    logic [AW:0]        r_inflight;

    // Tag delay line
    logic [PIPE_LATENCY-1:0]           r_dl_vld;
    logic [PIPE_LATENCY-1:0][ID_W-1:0] r_dl_id;
    logic                              w_tail_vld;
    logic [ID_W-1:0]                   w_tail_id;

    // Response FIFO
    rsp_entry_t  r_mem [FIFO_DEPTH];
    rsp_entry_t  w_head;
    rsp_entry_t  w_push_entry;
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        r_err;

    // Credit is judged on the registered count, so a pop only frees a slot
    // for the following cycle.
    assign w_can_issue = (r_inflight < DEPTH_L);

    cordic_rr_arb #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req_valid),
        .i_en    (w_can_issue),
        .i_adv   (w_xfer),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_any   (w_xfer)
    );

    assign o_req_ready       = w_gnt;
    assign o_cordic_valid_in = w_xfer;
    assign o_cordic_theta_in = w_xfer ? i_req_theta[w_gnt_idx] : '0;

    // Count issued-but-not-popped requests; issue and pop together cancel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_xfer, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Shift {valid, id} alongside the cordic so the tail lines up with valid_out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dl_vld <= '0;
            r_dl_id  <= '0;
        end else begin
            r_dl_vld <= {r_dl_vld[PIPE_LATENCY-2:0], w_xfer};
            r_dl_id  <= {r_dl_id[PIPE_LATENCY-2:0], w_gnt_idx};
        end
    end

    assign w_tail_vld = r_dl_vld[PIPE_LATENCY-1];
    assign w_tail_id  = r_dl_id[PIPE_LATENCY-1];

    // Extra pointer MSB distinguishes full from empty.
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = o_rsp_valid & i_rsp_ready;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign w_push  = w_tail_vld & (!w_full | w_pop);

    assign w_push_entry = '{id: ID_MAX_W'(w_tail_id), cos: i_cordic_cos, sin: i_cordic_sin};

    // Write captured results into the FIFO storage.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= w_push_entry;
    end

    // Advance FIFO pointers on push and pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage is not reset, so head fields are masked while empty.
    assign w_head      = r_mem[r_rd[AW-1:0]];
    assign o_rsp_valid = !w_empty;
    assign o_rsp_id    = o_rsp_valid ? w_head.id[ID_W-1:0] : '0;
    assign o_rsp_cos   = o_rsp_valid ? w_head.cos : '0;
    assign o_rsp_sin   = o_rsp_valid ? w_head.sin : '0;

    // Sticky error: cordic/tag disagreement or a result with nowhere to go.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_err <= 1'b0;
        else if ((i_cordic_valid_out != w_tail_vld) || (w_tail_vld && w_full && !w_pop))
            r_err <= 1'b1;
    end

    assign o_err = r_err;

`ifdef CORDIC_SCHED_STATS_EN
    logic [NUM_REQ-1:0][15:0] r_issue_cnt;
    logic [15:0]              r_stall_cnt;

    // Saturating per-requester transfer counts and credit-stall cycle count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i] && (r_issue_cnt[i] != 16'hFFFF))
                    r_issue_cnt[i] <= r_issue_cnt[i] + 16'd1;
            end
            if ((|i_req_valid) && !w_can_issue && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_issue_cnt = r_issue_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
